// File: rtl/vertex_smooth_if.sv
// Bundle of the start/busy/done handshake and the three RAM ports used by vertex_smooth.
// The slave side is the smoothing engine; the master side is its caller plus the RAM models.
interface vertex_smooth_if;
    logic        start;
    logic [31:0] vertex_count;
    logic        busy;
    logic        done;
    logic        err;

    logic        RAM_OBJ_EN;
    logic [8:0]  RAM_OBJ_A;
    logic [3:0]  RAM_OBJ_WE;
    logic [31:0] RAM_OBJ_Do;

    logic        RAM_NBR_EN;
    logic [8:0]  RAM_NBR_A;
    logic [3:0]  RAM_NBR_WE;
    logic [31:0] RAM_NBR_Do;

    logic        RAM_OUT_EN;
    logic [8:0]  RAM_OUT_A;
    logic [3:0]  RAM_OUT_WE;
    logic [31:0] RAM_OUT_Di;

    modport slave (
        input  start, vertex_count, RAM_OBJ_Do, RAM_NBR_Do,
        output busy, done, err,
        output RAM_OBJ_EN, RAM_OBJ_A, RAM_OBJ_WE,
        output RAM_NBR_EN, RAM_NBR_A, RAM_NBR_WE,
        output RAM_OUT_EN, RAM_OUT_A, RAM_OUT_WE, RAM_OUT_Di
    );

    modport master (
        output start, vertex_count, RAM_OBJ_Do, RAM_NBR_Do,
        input  busy, done, err,
        input  RAM_OBJ_EN, RAM_OBJ_A, RAM_OBJ_WE,
        input  RAM_NBR_EN, RAM_NBR_A, RAM_NBR_WE,
        input  RAM_OUT_EN, RAM_OUT_A, RAM_OUT_WE, RAM_OUT_Di
    );
endinterface

// File: rtl/vertex_smooth.sv
// Loop-subdivision even-vertex smoother: walks each vertex's neighbour list, accumulates
// neighbour positions and writes alpha*p + beta*sum back in the object-RAM vertex layout.
module vertex_smooth #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int FRAC_BITS          = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    vertex_smooth_if.slave bus
);
    localparam int         PW    = 42 + FRAC_BITS;
    localparam logic [3:0] MAX_N = 4'(MAX_NEIGHBOR_COUNT);

    typedef enum logic [3:0] {
        IDLE, RD_CNT, RD_NBR, RD_POS, RD_SELF, CALC, WR_X, WR_Y, WR_Z, NEXT, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ph_q, ph_d, ax_q, ax_d;
    logic [8:0]         v_q, v_d, vc_q, vc_d, u_q, u_d;
    logic [3:0]         n_q, n_d, m_q, m_d;
    logic [4:0]         j_q, j_d;
    logic signed [39:0] s_q [3];
    logic signed [39:0] s_d [3];
    logic signed [31:0] p_q [3];
    logic signed [31:0] p_d [3];
    logic               en_q, en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [8:0]         obj_a_q, obj_a_d, nbr_a_q, nbr_a_d, out_a_q, out_a_d;
    logic [3:0]         out_we_q, out_we_d;
    logic [31:0]        out_di_q, out_di_d;

    logic [FRAC_BITS-1:0] beta;
    logic [FRAC_BITS:0]   alpha;
    logic signed [PW-1:0] t_w [3];
    logic [31:0]          res [3];
    logic [8:0]           nbr_base;
    logic                 nbr_bad;
    logic                 unused_vc_hi;

    function automatic logic [8:0] pos_addr(input logic [8:0] w, input logic [1:0] k);
        logic [8:0] t;
        t = w - 9'd1;
        return 9'd2 + t + t + t + {7'd0, k};
    endfunction

    // m=3 is the classic 3/16; every other m uses 3/(8m), floored to the weight grid
    function automatic logic [FRAC_BITS-1:0] beta_of(input logic [3:0] m);
        logic [FRAC_BITS-1:0] b;
        b = '0;
        for (int i = 1; i < 16; i++) begin
            if (m == 4'(i))
                b = (i == 3) ? FRAC_BITS'((3 << FRAC_BITS) / 16)
                             : FRAC_BITS'((3 << FRAC_BITS) / (8 * i));
        end
        return b;
    endfunction

    assign unused_vc_hi = ^bus.vertex_count[31:9];
    assign nbr_base     = (v_q - 9'd1) * 9'(MAX_NEIGHBOR_COUNT);
    assign nbr_bad      = (bus.RAM_NBR_Do == 32'd0) || (bus.RAM_NBR_Do > {23'd0, vc_q});

    always_comb begin
        beta  = beta_of(m_q);
        alpha = (FRAC_BITS+1)'((1 << FRAC_BITS) - int'(m_q) * int'(beta));
        for (int k = 0; k < 3; k++) begin
            t_w[k] = (signed'(PW'(alpha)) * PW'(p_q[k]) + signed'(PW'(beta)) * PW'(s_q[k]))
                     >>> FRAC_BITS;
            res[k] = t_w[k][31:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        ax_d     = ax_q;
        v_d      = v_q;
        vc_d     = vc_q;
        u_d      = u_q;
        n_d      = n_q;
        m_d      = m_q;
        j_d      = j_q;
        s_d      = s_q;
        p_d      = p_q;
        en_d     = 1'b1;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        obj_a_d  = obj_a_q;
        nbr_a_d  = nbr_a_q;
        out_a_d  = out_a_q;
        out_we_d = 4'h0;
        out_di_d = out_di_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d = 1'b0;
                    v_d   = 9'd1;
                    vc_d  = bus.vertex_count[8:0];
                    ph_d  = 2'd0;
                    if (bus.vertex_count[8:0] == 9'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD_CNT;
                        busy_d  = 1'b1;
                    end
                end
            end
            RD_CNT: begin
                ph_d = ph_q + 2'd1;
                if (ph_q == 2'd0) nbr_a_d = nbr_base;
                if (ph_q == 2'd2) begin
                    n_d     = (bus.RAM_NBR_Do[3:0] > MAX_N) ? MAX_N : bus.RAM_NBR_Do[3:0];
                    s_d     = '{default: '0};
                    m_d     = 4'd0;
                    j_d     = 5'd1;
                    ax_d    = 2'd0;
                    ph_d    = 2'd0;
                    state_d = RD_NBR;
                end
            end
            RD_NBR: begin
                ph_d = ph_q + 2'd1;
                if (ph_q == 2'd0) begin
                    if (j_q > {1'b0, n_q}) begin
                        ph_d    = 2'd0;
                        ax_d    = 2'd0;
                        state_d = RD_SELF;
                    end else begin
                        nbr_a_d = nbr_base + {4'd0, j_q};
                    end
                end
                if (ph_q == 2'd2) begin
                    j_d  = j_q + 5'd1;
                    ph_d = 2'd0;
                    if (nbr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        u_d     = bus.RAM_NBR_Do[8:0];
                        ax_d    = 2'd0;
                        state_d = RD_POS;
                    end
                end
            end
            RD_POS, RD_SELF: begin
                ph_d = ph_q + 2'd1;
                if (ph_q == 2'd0) obj_a_d = pos_addr((state_q == RD_POS) ? u_q : v_q, ax_q);
                if (ph_q == 2'd2) begin
                    ph_d = 2'd0;
                    ax_d = ax_q + 2'd1;
                    if (state_q == RD_POS)
                        s_d[ax_q] = s_q[ax_q] + 40'(signed'(bus.RAM_OBJ_Do));
                    else
                        p_d[ax_q] = signed'(bus.RAM_OBJ_Do);
                    if (ax_q == 2'd2) begin
                        ax_d = 2'd0;
                        if (state_q == RD_POS) begin
                            m_d     = m_q + 4'd1;
                            state_d = RD_NBR;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
            end
            CALC: begin
                for (int k = 0; k < 3; k++) p_d[k] = signed'(res[k]);
                out_a_d  = pos_addr(v_q, 2'd0);
                out_di_d = res[0];
                out_we_d = 4'hF;
                state_d  = WR_X;
            end
            WR_X: begin
                out_a_d  = pos_addr(v_q, 2'd1);
                out_di_d = p_q[1];
                out_we_d = 4'hF;
                state_d  = WR_Y;
            end
            WR_Y: begin
                out_a_d  = pos_addr(v_q, 2'd2);
                out_di_d = p_q[2];
                out_we_d = 4'hF;
                state_d  = WR_Z;
            end
            WR_Z: state_d = NEXT;
            NEXT: begin
                ph_d = 2'd0;
                if (v_q == vc_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    v_d     = v_q + 9'd1;
                    state_d = RD_CNT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ph_q     <= '0;
            ax_q     <= '0;
            v_q      <= '0;
            vc_q     <= '0;
            u_q      <= '0;
            n_q      <= '0;
            m_q      <= '0;
            j_q      <= '0;
            s_q      <= '{default: '0};
            p_q      <= '{default: '0};
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            obj_a_q  <= '0;
            nbr_a_q  <= '0;
            out_a_q  <= '0;
            out_we_q <= '0;
            out_di_q <= '0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            ax_q     <= ax_d;
            v_q      <= v_d;
            vc_q     <= vc_d;
            u_q      <= u_d;
            n_q      <= n_d;
            m_q      <= m_d;
            j_q      <= j_d;
            s_q      <= s_d;
            p_q      <= p_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            obj_a_q  <= obj_a_d;
            nbr_a_q  <= nbr_a_d;
            out_a_q  <= out_a_d;
            out_we_q <= out_we_d;
            out_di_q <= out_di_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.RAM_OBJ_EN = en_q;
    assign bus.RAM_NBR_EN = en_q;
    assign bus.RAM_OUT_EN = en_q;
    assign bus.RAM_OBJ_A  = obj_a_q;
    assign bus.RAM_NBR_A  = nbr_a_q;
    assign bus.RAM_OUT_A  = out_a_q;
    assign bus.RAM_OBJ_WE = 4'h0;
    assign bus.RAM_NBR_WE = 4'h0;
    assign bus.RAM_OUT_WE = out_we_q;
    assign bus.RAM_OUT_Di = out_di_q;
endmodule

// File: tb/tb_vertex_smooth.sv
// Scoreboard bench for vertex_smooth: RAM models around the DUT, expected output writes
// are queued from an arithmetic reference model and checked by an independent monitor.
module tb_vertex_smooth;
    localparam int MAXN = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vertex_smooth_if bus();

    vertex_smooth #(.MAX_NEIGHBOR_COUNT(MAXN), .FRAC_BITS(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    logic [31:0] obj_mem [512];
    logic [31:0] nbr_mem [512];
    logic [31:0] out_mem [512];
    logic [31:0] exp_mem [512];

    typedef struct {
        logic [8:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t sb_q[$];

    int total = 0;
    int bad = 0;

    always @(posedge clk) begin
        if (bus.RAM_OBJ_EN) bus.RAM_OBJ_Do <= obj_mem[bus.RAM_OBJ_A];
        if (bus.RAM_NBR_EN) bus.RAM_NBR_Do <= nbr_mem[bus.RAM_NBR_A];
        if (bus.RAM_OUT_EN) begin
            for (int b = 0; b < 4; b++)
                if (bus.RAM_OUT_WE[b]) out_mem[bus.RAM_OUT_A][b*8 +: 8] <= bus.RAM_OUT_Di[b*8 +: 8];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bus.RAM_OUT_EN && bus.RAM_OUT_WE != 4'h0) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         bus.RAM_OUT_A, bus.RAM_OUT_Di);
            end else begin
                e = sb_q.pop_front();
                chk("wr_we", bus.RAM_OUT_WE, 4'hF);
                chk("wr_addr", bus.RAM_OUT_A, e.a);
                chk("wr_data", bus.RAM_OUT_Di, e.d);
            end
        end
        if (rst_n && (bus.RAM_OBJ_WE != 4'h0 || bus.RAM_NBR_WE != 4'h0)) begin
            total++;
            bad++;
            $display("FAIL input_ram_we: got %0h/%0h expected 0/0", bus.RAM_OBJ_WE, bus.RAM_NBR_WE);
        end
    end

    // Reference: beta = 3/16 for three neighbours, else floor(3*2^16/(8m)); floor shift
    function automatic logic [31:0] smooth_axis(input longint p, input longint s, input int m);
        longint beta, alpha, r;
        beta  = (m == 0) ? 0 : (m == 3) ? (3 * 65536) / 16 : (3 * 65536) / (8 * m);
        alpha = 65536 - m * beta;
        r     = (alpha * p + beta * s) >>> 16;
        return r[31:0];
    endfunction

    task automatic build_expected(input int vc, output bit e_err);
        e_err = 1'b0;
        for (int v = 1; v <= vc; v++) begin
            int base, n, m, oa;
            longint u, r;
            longint s[3];
            logic [31:0] cw, rv;
            base = (v - 1) * MAXN;
            cw   = nbr_mem[base];
            n    = int'(cw[3:0]);
            if (n > MAXN) n = MAXN;
            m = 0;
            s = '{0, 0, 0};
            for (int j = 1; j <= n; j++) begin
                u = longint'(nbr_mem[base + j]);
                if (u == 0 || u > vc) e_err = 1'b1;
                else begin
                    for (int k = 0; k < 3; k++) begin
                        r = int'(obj_mem[2 + 3 * (int'(u) - 1) + k]);
                        s[k] += r;
                    end
                    m++;
                end
            end
            for (int k = 0; k < 3; k++) begin
                oa = 2 + 3 * (v - 1) + k;
                r  = int'(obj_mem[oa]);
                rv = smooth_axis(r, s[k], m);
                exp_mem[oa] = rv;
                sb_q.push_back('{a: 9'(oa), d: rv});
            end
        end
    endtask

    task automatic set_pos(input int v, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        obj_mem[2 + 3 * (v - 1)]     = x;
        obj_mem[2 + 3 * (v - 1) + 1] = y;
        obj_mem[2 + 3 * (v - 1) + 2] = z;
    endtask

    task automatic set_nbr(input int v, input int j, input int val);
        nbr_mem[(v - 1) * MAXN + j] = 32'(val);
    endtask

    task automatic fill_random(input int vc);
        for (int v = 1; v <= vc; v++) begin
            int r;
            set_pos(v, $urandom, $urandom, $urandom);
            set_nbr(v, 0, $urandom_range(0, 15));
            for (int j = 1; j <= ((v == vc) ? 10 : 9); j++) begin
                r = $urandom_range(0, 9);
                set_nbr(v, j, (r == 0) ? 0 : (r == 1) ? vc + 1 : $urandom_range(1, vc));
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_obj_en"}, bus.RAM_OBJ_EN, 0);
        chk({tag, "_nbr_en"}, bus.RAM_NBR_EN, 0);
        chk({tag, "_out_en"}, bus.RAM_OUT_EN, 0);
        chk({tag, "_obj_a"}, bus.RAM_OBJ_A, 0);
        chk({tag, "_nbr_a"}, bus.RAM_NBR_A, 0);
        chk({tag, "_out_a"}, bus.RAM_OUT_A, 0);
        chk({tag, "_out_we"}, bus.RAM_OUT_WE, 0);
        chk({tag, "_out_di"}, bus.RAM_OUT_Di, 0);
        chk({tag, "_obj_we"}, bus.RAM_OBJ_WE, 0);
        chk({tag, "_nbr_we"}, bus.RAM_NBR_WE, 0);
    endtask

    task automatic run_vs(input int vc, input string tag);
        bit e_err, seen;
        int cyc;
        build_expected(vc, e_err);
        @(negedge clk);
        bus.vertex_count = 32'(vc);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (vc != 0) chk({tag, "_busy_rise"}, bus.busy, 1);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 250 * vc + 20) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            bus.start = (cyc == 20) && bus.busy;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_busy_at_done"}, bus.busy, 0);
            chk({tag, "_err"}, bus.err, e_err);
            chk({tag, "_sb_empty"}, sb_q.size(), 0);
            @(negedge clk);
            chk({tag, "_done_pulse"}, bus.done, 0);
        end else begin
            rst_n = 1'b0;
            sb_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit e_err, found;
        int cyc;
        bus.start = 1'b0;
        bus.vertex_count = 32'd0;
        for (int i = 0; i < 512; i++) begin
            obj_mem[i] = '0;
            nbr_mem[i] = '0;
            out_mem[i] = '0;
            exp_mem[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        // triangle
        set_pos(1, 32'h0, 32'h0, 32'h0);
        set_pos(2, 32'h10000, 32'h0, 32'h0);
        set_pos(3, 32'h0, 32'h10000, 32'h0);
        set_nbr(1, 0, 2); set_nbr(1, 1, 2); set_nbr(1, 2, 3);
        set_nbr(2, 0, 2); set_nbr(2, 1, 1); set_nbr(2, 2, 3);
        set_nbr(3, 0, 2); set_nbr(3, 1, 1); set_nbr(3, 2, 2);
        run_vs(3, "tri");
        chk("tri_v1x", out_mem[2], 32'h3000);
        chk("tri_v1y", out_mem[3], 32'h3000);
        chk("tri_v1z", out_mem[4], 32'h0);
        chk("tri_v2x", out_mem[5], 32'hA000);
        chk("tri_v2y", out_mem[6], 32'h3000);
        chk("tri_v3x", out_mem[8], 32'h3000);
        chk("tri_v3y", out_mem[9], 32'hA000);

        // invalid indices 0 and vertex_count+1
        set_nbr(1, 0, 3); set_nbr(1, 1, 2); set_nbr(1, 2, 0); set_nbr(1, 3, 3);
        set_nbr(2, 0, 2); set_nbr(2, 1, 4); set_nbr(2, 2, 1);
        for (int v = 1; v <= 3; v++) set_pos(v, $urandom, $urandom, $urandom);
        run_vs(3, "badidx");

        // isolated vertex copies through; also clears the sticky err
        set_pos(1, 32'h12345678, -32'sd5, 32'd7);
        set_nbr(1, 0, 0);
        run_vs(1, "copy");
        chk("copy_x", out_mem[2], 32'h12345678);
        chk("copy_y", out_mem[3], 32'hFFFFFFFB);
        chk("copy_z", out_mem[4], 32'h7);

        // single neighbour, negative coordinate floors
        set_pos(1, 32'hFFFF0000, 32'h0, 32'h0);
        set_pos(2, 32'h0, 32'h0, 32'h0);
        set_nbr(1, 0, 1); set_nbr(1, 1, 2);
        set_nbr(2, 0, 0);
        run_vs(2, "single");
        chk("single_x", out_mem[2], 32'hFFFF6000);

        // count word 14 is capped at MAXN; extra words would be invalid if read
        set_pos(1, 32'h10000, 32'h0, 32'h0);
        set_pos(2, 32'h10000, 32'h0, 32'h0);
        set_pos(3, 32'h0, 32'h0, 32'h0);
        set_nbr(1, 0, 0); set_nbr(2, 0, 0);
        set_nbr(3, 0, 14);
        for (int j = 1; j <= 10; j++) set_nbr(3, j, (j % 2) + 1);
        for (int j = 11; j <= 14; j++) set_nbr(3, j, 0);
        run_vs(3, "cap");
        chk("cap_v3x", out_mem[8], 32'h5FFA);

        run_vs(0, "zero");

        for (int it = 0; it < 6; it++) begin
            int vc;
            vc = $urandom_range(1, 12);
            fill_random(vc);
            run_vs(vc, $sformatf("rand%0d", it));
        end

        // abort during the y write of vertex 2, then a clean rerun
        for (int i = 0; i < 512; i++) out_mem[i] = '0;
        fill_random(4);
        build_expected(4, e_err);
        @(negedge clk);
        bus.vertex_count = 32'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 1'b0;
        cyc = 0;
        while (cyc < 1200 && !found) begin
            @(negedge clk);
            cyc++;
            if (bus.RAM_OUT_WE != 4'h0 && bus.RAM_OUT_A == 9'd6) found = 1'b1;
        end
        chk("abort_trigger_seen", found, 1);
        rst_n = 1'b0;
        #1;
        chk_reset("abort");
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vs(4, "rerun");
        for (int a = 2; a < 14; a++) chk($sformatf("rerun_mem%0d", a), out_mem[a], exp_mem[a]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vertex_smooth.md
Name: vertex_smooth

Overview:
- Stage directly downstream of the neighbour-list builder. Consumes the neighbour RAM it fills, plus the vertex positions in the object RAM.
- Computes Loop-style smoothed (even-vertex) positions and writes them to an output RAM using the object RAM's vertex layout, so the output can feed the next subdivision pass.
- Runs one vertex at a time as a start/busy/done controlled sequencer.

Parameters:
MAX_NEIGHBOR_COUNT, 10, words per vertex block in neighbour RAM (word0 = count, words 1..count = 1-based vertex indices); supported range 1..15
FRAC_BITS, 16, fractional bits of Q16.16 coordinates and of the Q0.16 weights

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  level; sampled only in IDLE
vertex_count  in  32  number of vertices; only [8:0] used
RAM_OBJ_Do  in  32  object RAM read data
RAM_NBR_Do  in  32  neighbour RAM read data
RAM_OBJ_EN, RAM_NBR_EN, RAM_OUT_EN  out  1  RAM enables
RAM_OBJ_A, RAM_NBR_A, RAM_OUT_A  out  9  RAM addresses
RAM_OBJ_WE, RAM_NBR_WE  out  4  tied 0 (this block only reads these RAMs)
RAM_OUT_WE  out  4  byte write enables for output RAM
RAM_OUT_Di  out  32  output RAM write data
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse on completion
err  out  1  sticky invalid-neighbour flag; cleared on the next accepted start

Behaviour:
- Reset values: all A, Di and WE outputs 0; EN outputs 0; busy, done and err 0; state IDLE. Reset mid-operation aborts at once; RAM_OUT keeps any words already written.
- RAM timing: synchronous read. Data for an address registered at edge k is sampled at edge k+2, so there is one wait cycle per read.
- Object layout: vertex v (1-based) has x, y, z at 2+3(v-1)+{0,1,2}. Output uses the same addresses.
- Neighbour layout: the block for v starts at (v-1)*MAX_NEIGHBOR_COUNT.
- FSM states: IDLE, RD_CNT, RD_NBR, RD_POS, RD_SELF, CALC, WR_X, WR_Y, WR_Z, NEXT, DONE.
- IDLE: EN=1. If start=1: clear err, set v=1, assert busy, go to RD_CNT. If vertex_count=0, go directly to DONE instead.
- RD_CNT: read the count word. n_raw = Do[3:0]. If n_raw exceeds MAX_NEIGHBOR_COUNT, use MAX_NEIGHBOR_COUNT. Clear the 40-bit signed accumulators Sx, Sy, Sz and set valid-neighbour count m=0.
- RD_NBR: for each j in 1..n, read index u.
  - If u=0 or u>vertex_count: set err and skip u.
  - Otherwise go to RD_POS.
- RD_POS: read x, y, z of u. Sign-extend each and add to Sx, Sy, Sz; increment m. Return to RD_NBR for the next j.
- RD_SELF: after all n indices, read the vertex's own x, y, z.
- CALC: weights come from LUT[m], Q0.16 beta:
  - values for m=0..10: 0, 24576, 12288, 12288, 6144, 4915, 4096, 3510, 3072, 2730, 2457.
  - m=3 uses 3/16; every other m≥1 uses floor(65536*3/(8m)); a generic MAX_NEIGHBOR_COUNT extends the table with floor(65536*3/(8m)).
  - alpha = 65536 - m*beta (17-bit unsigned).
  - Per axis: r = (alpha*p + beta*S) >>> 16, with full-width signed products, arithmetic shift (floor), then truncated to 32 bits.
  - m=0 means an exact copy of the vertex.
- WR_X/WR_Y/WR_Z: one write per cycle, WE=4'b1111, addresses 2+3(v-1)+0/1/2. WE returns to 0 in NEXT.
- NEXT: if v=vertex_count[8:0], go to DONE; otherwise v=v+1 and go to RD_CNT.
- DONE: one cycle. done=1, busy=0, then go to IDLE. If start is still held high, a new run starts in the following IDLE cycle.
- start while busy is ignored.
- Address arithmetic is 9-bit and wraps. The caller must ensure vertex_count*3+2 < 512.
- RAM_OBJ_WE and RAM_NBR_WE are never nonzero.

Test Plan:
- Triangle: v1=(0,0,0), v2=(0x10000,0,0), v3=(0,0x10000,0); each vertex has count 2 and the other two as neighbours -> v1 out=(0x3000,0x3000,0), v2 out=(0xA000,0x3000,0), v3 out=(0x3000,0xA000,0). busy falls, done pulses once, err=0.
- Vertex with count 0 and pos (0x12345678,-5,7) -> output identical to input.
- Single neighbour, v=(0xFFFF0000,0,0), neighbour at origin -> out x=0xFFFF6000 (floor of -40960).
- Count word=14 with MAX_NEIGHBOR_COUNT=10 -> only 10 indices read; weight uses m=10 (beta 2457).
- Neighbour index 0 or vertex_count+1 in a list -> index skipped, m reduced, err=1 until the next start; remaining vertices are still processed correctly.
- rst_n pulsed low during WR_Y of vertex 2 -> all outputs return to reset values immediately. The following start reprocesses every vertex and produces final contents equal to a clean run.
